// File: rtl/icache_tag_ctrl.sv
// Tag-array controller for a 2-way set-associative instruction cache:
// power-up/flush invalidation, lookup, LRU victim choice and line refill.
module icache_tag_ctrl #(
  parameter int addr_width = 4,
  parameter int tag_width  = 25,
  parameter int way        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  output logic [way-1:0]        resp_way,
  input  logic                  flush_req,
  output logic [addr_width-1:0] TagV_addr_read,
  output logic [tag_width:0]    TagV_din_compare,
  input  logic [way-1:0]        hit,
  output logic [addr_width-1:0] TagV_addr_write,
  output logic [tag_width:0]    TagV_din_write,
  output logic [way-1:0]        TagV_we,
  output logic [way-1:0]        data_we,
  output logic                  mem_req,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_addr,
  input  logic                  mem_resp_valid
);

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS, REFILL, WRITE} state_t;

  state_t                       state;
  logic [addr_width-1:0]        cnt;
  logic [addr_width-1:0]        idx_q;
  logic [tag_width-1:0]         tag_q;
  logic                         victim_q;
  logic [(1<<addr_width)-1:0]   lru;

  logic [addr_width-1:0]        req_idx;
  logic [tag_width-1:0]         req_tag;
  logic [way-1:0]               hit_way;
  logic [way-1:0]               victim_oh;
  logic                         unused_offset;

  assign req_idx       = req_addr[3 +: addr_width];
  assign req_tag       = req_addr[3 + addr_width +: tag_width];
  assign unused_offset = ^req_addr[2:0];

  assign mem_addr        = {tag_q, idx_q, 3'b000};
  assign TagV_addr_write = (state == INIT) ? cnt : idx_q;
  assign TagV_din_write  = (state == INIT) ? '0 : {1'b1, tag_q};

  // Lowest-numbered hitting way wins if the array reports more than one.
  always_comb begin
    hit_way = '0;
    for (int w = way - 1; w >= 0; w--) begin
      if (hit[w]) begin
        hit_way    = '0;
        hit_way[w] = 1'b1;
      end
    end
  end

  always_comb begin
    victim_oh           = '0;
    victim_oh[victim_q] = 1'b1;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_way         = '0;
    TagV_we          = '0;
    data_we          = '0;
    mem_req          = 1'b0;
    TagV_addr_read   = idx_q;
    TagV_din_compare = {1'b1, tag_q};
    unique case (state)
      INIT: TagV_we = '1;
      IDLE: begin
        req_ready        = !flush_req;
        TagV_addr_read   = req_idx;
        TagV_din_compare = {1'b1, req_tag};
      end
      LOOKUP: begin
        if (|hit) begin
          resp_valid = 1'b1;
          resp_way   = hit_way;
          req_ready  = 1'b1;
          if (req_valid) begin
            TagV_addr_read   = req_idx;
            TagV_din_compare = {1'b1, req_tag};
          end
        end
      end
      MISS: mem_req = 1'b1;
      REFILL: begin
        if (mem_resp_valid) begin
          TagV_we = victim_oh;
          data_we = victim_oh;
        end
      end
      default: ;
    endcase
    // A reset cycle must never hand out a request slot or commit a refill.
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      TagV_we    = '0;
      data_we    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
      victim_q <= 1'b0;
      // NOTE: lru is small flop storage, not a RAM, so it is cleared here;
      // flush deliberately leaves it alone.
      lru      <= '0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= IDLE;
        end
        IDLE: begin
          if (flush_req) begin
            state <= INIT;
            cnt   <= '0;
          end else if (req_valid) begin
            idx_q <= req_idx;
            tag_q <= req_tag;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (|hit) begin
            // Point lru at the way that did not hit.
            lru[idx_q] <= hit_way[0];
            if (req_valid) begin
              idx_q <= req_idx;
              tag_q <= req_tag;
            end else begin
              state <= IDLE;
            end
          end else begin
            victim_q <= lru[idx_q];
            state    <= MISS;
          end
        end
        MISS:   if (mem_req_ready) state <= REFILL;
        REFILL: if (mem_resp_valid) state <= WRITE;
        WRITE: begin
          lru[idx_q] <= ~victim_q;
          state      <= LOOKUP;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
